// File: rtl/kgp_trace_pkg.sv
// Shared types and width helpers for the KGP-RISC trace-capture block.
// TRACE_TIMESTAMP_EN enables per-sample cycle timestamps.
package kgp_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TS_W = 32;

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_DEPTH = 16;
  localparam int DEF_IDX_W = idx_w(DEF_DEPTH);
  localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Contents are not reset; the capture logic masks reads outside DONE.
module trace_ram #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Circular trace buffer for KGP-RISC channels, frozen POST_TRIG samples after a masked trigger on ch0.
// Define TRACE_TIMESTAMP_EN to store a 32-bit cycle stamp per sample and expose rd_ts.
module cpu_trace_capture
  import kgp_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int IDX_W    = idx_w(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     sample_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  output logic [IDX_W-1:0]         trig_pos
);

  localparam int CH_W = NUM_CH * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RAM_W = CH_W + TS_W;
`else
  localparam int RAM_W = CH_W;
`endif

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr_ptr, trig_idx, post_cnt, post_nxt, oldest, rd_addr;
  logic [CNT_W-1:0] count_q;
  logic             trig_q, rd_valid_q, rd_oob_q;
  logic             arm_ok, hit, wr_en, re;
  logic [RAM_W-1:0] wdata, ram_q;

  assign arm_ok   = arm && (state == IDLE || state == DONE);
  assign hit      = sample_en &&
                    ((ch_data[DATA_W-1:0] & trig_mask) == (trig_value & trig_mask));
  assign wr_en    = sample_en && (state == ARMED || state == POST);
  assign post_nxt = post_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arm) state_nxt = ARMED;
      ARMED: if (hit) state_nxt = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (sample_en && post_nxt == IDX_W'(POST_TRIG)) state_nxt = DONE;
      DONE:  if (arm) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      count_q  <= '0;
      post_cnt <= '0;
      trig_idx <= '0;
      trig_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm_ok) begin
        wr_ptr   <= '0;
        count_q  <= '0;
        post_cnt <= '0;
        trig_idx <= '0;
        trig_q   <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count_q != CNT_W'(DEPTH)) count_q <= count_q + 1'b1;
        if (state == ARMED && hit) begin
          trig_q   <= 1'b1;
          trig_idx <= wr_ptr;
        end
        if (state == POST) post_cnt <= post_nxt;
      end
    end
  end

  // Until the buffer has wrapped, entry 0 is the oldest sample.
  assign oldest  = (count_q == CNT_W'(DEPTH)) ? wr_ptr : '0;
  assign rd_addr = oldest + rd_idx;
  assign re      = rd_en && state == DONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= re && !arm;
      rd_oob_q   <= CNT_W'(rd_idx) >= count_q;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 1'b1;
  end

  assign wdata = {ts_q, ch_data};
  assign rd_ts = (rd_valid_q && !rd_oob_q) ? ram_q[RAM_W-1:CH_W] : '0;
`else
  assign wdata = ch_data;
`endif

  trace_ram #(.W(RAM_W), .DEPTH(DEPTH), .AW(IDX_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_data   = (rd_valid_q && !rd_oob_q) ? ram_q[CH_W-1:0] : '0;
  assign busy      = (state == ARMED) || (state == POST);
  assign done      = (state == DONE);
  assign triggered = trig_q;
  assign count     = count_q;
  assign trig_pos  = done ? (trig_idx - oldest) : '0;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture: ramp, early, opcode, gapped and reset-abort captures.
// Build with TRACE_TIMESTAMP_EN to also check rd_ts spacing.
module tb_cpu_trace_capture;

  logic         clk = 1'b0, rst = 1'b0, arm = 1'b0, sample_en = 1'b0, rd_en = 1'b0;
  logic [127:0] ch_data = '0;
  logic [31:0]  trig_value = '0, trig_mask = '0;
  logic [3:0]   rd_idx = '0;
  logic         rd_valid, busy, triggered, done;
  logic [127:0] rd_data;
  logic [4:0]   count;
  logic [3:0]   trig_pos;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]  rd_ts, ts_a;
`endif
  int           total = 0, bad = 0;
  int           last;
  logic [31:0]  s3v [6];

  cpu_trace_capture #(.DATA_W(32), .NUM_CH(4), .DEPTH(16), .POST_TRIG(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_en(sample_en), .ch_data(ch_data),
    .trig_value(trig_value), .trig_mask(trig_mask), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .busy(busy), .triggered(triggered), .done(done), .count(count), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] word(input logic [31:0] c0);
    return {c0 + 32'h3000_0000, c0 + 32'h2000_0000, c0 + 32'h1000_0000, c0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] v, input logic [31:0] m);
    trig_value = v;
    trig_mask  = m;
    sample_en  = 1'b0;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Streams ch0 = 0,1,2,... until done; returns the last sample number written.
  task automatic ramp(output int lst);
    logic [31:0] n;
    n   = 0;
    lst = -1;
    while (!done && n < 200) begin
      ch_data   = word(n);
      sample_en = 1'b1;
      tick();
      lst = int'(n);
      n++;
    end
    sample_en = 1'b0;
    chk("ramp_done", done, 1);
  endtask

  task automatic rd(input logic [3:0] i);
    rd_idx = i;
    rd_en  = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic scen_ramp(input string p);
    do_arm(32'd40, 32'hFFFF_FFFF);
    chk({p, "_busy"}, busy, 1);
    ramp(last);
    chk({p, "_last"}, last, 44);
    chk({p, "_count"}, count, 16);
    chk({p, "_trig_pos"}, trig_pos, 11);
    chk({p, "_triggered"}, triggered, 1);
    chk({p, "_busy_done"}, busy, 0);
    rd(4'd0);
    chk({p, "_rv0"}, rd_valid, 1);
    chk({p, "_rd0"}, rd_data, word(29));
`ifdef TRACE_TIMESTAMP_EN
    ts_a = rd_ts;
`endif
    rd(4'd15);
    chk({p, "_rd15"}, rd_data, word(44));
`ifdef TRACE_TIMESTAMP_EN
    chk({p, "_ts_delta"}, rd_ts - ts_a, 15);
`endif
    rd(4'd11);
    chk({p, "_rdtrig"}, rd_data, word(40));
  endtask

  initial begin
    s3v = '{32'h0400_0001, 32'h0800_ABCD, 32'h0C00_0002, 32'h0800_1111, 32'h1000_0003, 32'h1400_0004};

    // Reset state
    #12;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_triggered", triggered, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) tick();

    // rd_en in IDLE is ignored
    rd(4'd0);
    chk("idle_rd_valid", rd_valid, 0);

    scen_ramp("s1");

    // Early trigger: buffer never wraps
    do_arm(32'd2, 32'hFFFF_FFFF);
    chk("s2_rearm_count", count, 0);
    chk("s2_rearm_trig", triggered, 0);
    ramp(last);
    chk("s2_last", last, 6);
    chk("s2_count", count, 7);
    chk("s2_trig_pos", trig_pos, 2);
    rd(4'd6);
    chk("s2_rd6", rd_data, word(6));
    chk("s2_rv6", rd_valid, 1);
    rd(4'd7);
    chk("s2_rd7_data", rd_data, 0);
    chk("s2_rd7_valid", rd_valid, 1);
    rd(4'd0);
    chk("s2_rd0", rd_data, word(0));

    // Opcode trigger on the top 6 bits of ch0
    do_arm(32'h0800_0000, 32'hFC00_0000);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("s3_not_done_5", done, 0);
      ch_data   = word(s3v[i]);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    chk("s3_done", done, 1);
    chk("s3_count", count, 6);
    chk("s3_trig_pos", trig_pos, 1);
    rd(4'd1);
    chk("s3_rd1", rd_data, word(32'h0800_ABCD));
    rd(4'd3);
    chk("s3_rd3", rd_data, word(32'h0800_1111));

    // mask=0 triggers on first sample; gapped sample_en in POST
    do_arm(32'hDEAD_BEEF, 32'h0);
    ch_data   = word(100);
    sample_en = 1'b1;
    tick();
    chk("s4_triggered", triggered, 1);
    for (int q = 1; q <= 4; q++) begin
      sample_en = 1'b0;
      rd_en     = 1'b1;
      rd_idx    = 4'd0;
      tick();
      rd_en = 1'b0;
      chk("s4_busy_rd_valid", rd_valid, 0);
      chk("s4_gap_done", done, 0);
      ch_data   = word(100 + q);
      sample_en = 1'b1;
      tick();
      if (q < 4) chk("s4_early_done", done, 0);
    end
    sample_en = 1'b0;
    chk("s4_done", done, 1);
    chk("s4_count", count, 5);
    chk("s4_trig_pos", trig_pos, 0);
    rd(4'd4);
    chk("s4_rd4", rd_data, word(104));

    // Asynchronous reset mid-POST
    do_arm(32'd40, 32'hFFFF_FFFF);
    for (int n = 0; n <= 42; n++) begin
      ch_data   = word(n);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    chk("s5_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_count", count, 0);
    chk("s5_triggered", triggered, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    scen_ramp("s5r");

    // arm and rd_en together in DONE: arm wins
    trig_value = 32'hFFFF_FFFF;
    trig_mask  = 32'hFFFF_FFFF;
    arm    = 1'b1;
    rd_en  = 1'b1;
    rd_idx = 4'd0;
    tick();
    arm   = 1'b0;
    rd_en = 1'b0;
    chk("s6_rd_valid", rd_valid, 0);
    chk("s6_busy", busy, 1);
    chk("s6_count", count, 0);
    chk("s6_trig_pos", trig_pos, 0);

    // arm while ARMED does not restart
    ch_data   = word(7);
    sample_en = 1'b1;
    arm       = 1'b1;
    tick();
    arm       = 1'b0;
    sample_en = 1'b0;
    chk("s6_arm_ignored_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Parametrised, synthesizable trace-capture block for the KGP-RISC CPU.
- Samples NUM_CH CPU-observable channels (e.g. inst, OLD_PC, ALU_Result, a register tap) into a circular buffer every qualified cycle.
- Freezes the buffer a programmable number of samples after a masked-compare trigger on channel 0.
- Captured window is read out by a host or bench through a one-cycle-latency read port.

Parameters:
- DATA_W, 32: width of each channel.
- NUM_CH, 4: number of channels captured per sample; channel 0 is the trigger channel.
- DEPTH, 16: buffer entries; power of two, ≥ 4.
- POST_TRIG, 4: samples stored after the trigger sample; legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  start a new capture; honoured only in IDLE or DONE.
- sample_en  in  1  qualifies ch_data as a sample this cycle.
- ch_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- trig_value  in  DATA_W  trigger compare value.
- trig_mask  in  DATA_W  trigger compare mask; 1 = bit compared.
- rd_en  in  1  read request.
- rd_idx  in  clog2(DEPTH)  entry index; 0 = oldest stored sample.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  NUM_CH*DATA_W  read entry.
- busy  out  1  state is ARMED or POST.
- triggered  out  1  trigger seen in the current capture.
- done  out  1  state is DONE.
- count  out  clog2(DEPTH+1)  number of valid entries, saturating at DEPTH.
- trig_pos  out  clog2(DEPTH)  index of the trigger sample relative to the oldest entry.

Behaviour:
- Reset (rst=0, asynchronous): state = IDLE. All outputs 0. Pointers and counters cleared. Buffer RAM is not reset; contents are unreadable until DONE.
- States:
  - IDLE: no writes; arm → ARMED (count cleared).
  - ARMED: each sample_en cycle writes ch_data at wr_ptr, wr_ptr++ (wraps mod DEPTH), count saturates at DEPTH.
    - Trigger condition: sample_en && ((ch0 & trig_mask) == (trig_value & trig_mask)).
    - On trigger the sample is written, triggered=1 next cycle, and trigger write index is latched.
    - Next state: POST, or DONE if POST_TRIG=0.
    - trig_mask=0 triggers on the first sample.
  - POST: sample_en cycles write as in ARMED and increment post_cnt. The write making post_cnt == POST_TRIG moves to DONE next cycle. Further triggers are ignored.
  - DONE: no writes; done=1; buffer frozen. arm → ARMED, clearing count, triggered and trig_pos.
- sample_en=0: no write, no trigger evaluation, post_cnt holds.
- Oldest entry:
  - count < DEPTH: oldest = entry 0.
  - Otherwise: oldest = wr_ptr.
  - trig_pos = (trigger write index − oldest) mod DEPTH, valid from DONE.
  - POST_TRIG < DEPTH guarantees the trigger sample is retained.
- Read port:
  - rd_en in DONE: rd_valid=1 and rd_data = entry (oldest + rd_idx) mod DEPTH one cycle later.
  - rd_idx ≥ count: rd_data = 0 with rd_valid=1.
  - rd_en outside DONE: rd_valid stays 0.
- arm has no effect in ARMED/POST (no restart mid-capture).
- arm and rd_en together in DONE: arm wins, rd_valid=0 next cycle.
- Reset mid-capture: immediate return to IDLE; partial capture discarded.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter, cleared by reset, increments every clk.
  - Its value is stored alongside each written sample.
  - Extra output rd_ts [31:0] is returned with rd_data under the same rd_valid timing; rd_ts = 0 when rd_idx ≥ count.
- Undefined: no counter, no rd_ts port, RAM width NUM_CH*DATA_W.

Decomposition:
- Package kgp_trace_pkg:
  - State encoding: IDLE=2'd0, ARMED=2'd1, POST=2'd2, DONE=2'd3.
  - Index-width helper (clog2) constants.
  - Timestamp width constant TS_W=32.
- One sub-module, trace_ram:
  - Simple dual-port, one write port and one registered read port.
  - Width NUM_CH*DATA_W (+TS_W when enabled), depth DEPTH.
- FSM, pointers and trigger compare stay in cpu_trace_capture.

Test Plan:
- Defaults; ch0 = sample number n (sample_en every cycle); trig_value=40, mask=32'hFFFFFFFF → done after sample 44, count=16, trig_pos=11; rd_idx 0 → ch0=29, rd_idx 15 → ch0=44.
- Early trigger at n=2 → count=7, trig_pos=2; rd_idx 6 → ch0=6; rd_idx 7 → rd_data=0, rd_valid=1.
- Opcode trigger: mask=32'hFC000000, value=32'h08000000; ch0 stream 32'h04000001, 32'h0800ABCD, … → trigger on the second sample, trig_pos=1.
- sample_en low on alternate cycles during POST → done asserted only after 4 qualified samples; rd_valid stays 0 for rd_en issued while busy=1.
- rst driven low mid-POST → busy=0, done=0, count=0 asynchronously; arm after release → clean new capture matching the first scenario.
- TRACE_TIMESTAMP_EN defined, first scenario with arm at cycle 10 after reset → rd_ts for rd_idx 0 equals rd_ts for rd_idx 15 minus 15.
